// File: rtl/gate_tester_if.sv
// Bundles the gate_tester run-control/status signals and the gate-block a/b/y links.
// GATE_TESTER_FAIL_CAPTURE_EN adds the first-failure capture signals.
`timescale 1ns/1ps
interface gate_tester_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             a;
  logic             b;
  logic [5:0]       y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       fail_vec;
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
  logic [1:0]       first_fail_idx;
  logic [5:0]       first_fail_y;
  logic             first_fail_vld;

  modport master (
    input  start, y,
    output a, b, busy, done, pass, err_cnt, fail_vec,
           first_fail_idx, first_fail_y, first_fail_vld
  );
  modport slave (
    output start, y,
    input  a, b, busy, done, pass, err_cnt, fail_vec,
           first_fail_idx, first_fail_y, first_fail_vld
  );
`else
  modport master (
    input  start, y,
    output a, b, busy, done, pass, err_cnt, fail_vec
  );
  modport slave (
    output start, y,
    input  a, b, busy, done, pass, err_cnt, fail_vec
  );
`endif
endinterface

// File: rtl/gate_tester.sv
// Self-test sequencer for the two-input gate block: walks ab=00..11, compares y to the truth table.
// Optional GATE_TESTER_FAIL_CAPTURE_EN latches the index and raw y of the first failing vector.
`timescale 1ns/1ps
module gate_tester #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic          clk,
  input  logic          rst,
  gate_tester_if.master bus
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [SC_W-1:0]  scnt, scnt_nxt;
  logic             a_r, a_nxt, b_r, b_nxt;
  logic             busy_r, busy_nxt, done_r, done_nxt, pass_r, pass_nxt;
  logic [CNT_W-1:0] err_r, err_nxt;
  logic [3:0]       fv_r, fv_nxt;
  logic [5:0]       mism;
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
  logic [1:0]       ffi_r, ffi_nxt;
  logic [5:0]       ffy_r, ffy_nxt;
  logic             ffv_r, ffv_nxt;
`endif

  function automatic logic [5:0] golden(input logic [1:0] v);
    logic ga, gb;
    ga = v[1];
    gb = v[0];
    return {ga ^ gb, ~(ga | gb), ~(ga & gb), ~ga, ga | gb, ga & gb};
  endfunction

  function automatic logic [2:0] popcount6(input logic [5:0] m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 6; i++) c = c + 3'(m[i]);
    return c;
  endfunction

  // Wide enough that a narrow counter plus up to six new mismatches cannot wrap before the clamp.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc, input logic [2:0] inc);
    logic [CNT_W+2:0] sum;
    sum = (CNT_W+3)'(acc) + (CNT_W+3)'(inc);
    return (sum > (CNT_W+3)'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  assign mism = bus.y ^ golden(idx);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    scnt_nxt  = scnt;
    a_nxt     = a_r;
    b_nxt     = b_r;
    busy_nxt  = busy_r;
    done_nxt  = done_r;
    pass_nxt  = pass_r;
    err_nxt   = err_r;
    fv_nxt    = fv_r;
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
    ffi_nxt   = ffi_r;
    ffy_nxt   = ffy_r;
    ffv_nxt   = ffv_r;
`endif
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = SETTLE;
          idx_nxt   = 2'd0;
          scnt_nxt  = '0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          err_nxt   = '0;
          fv_nxt    = 4'b0000;
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
          ffi_nxt   = 2'd0;
          ffy_nxt   = 6'd0;
          ffv_nxt   = 1'b0;
`endif
        end
      end
      SETTLE: begin
        scnt_nxt = scnt + 1'b1;
        if (scnt == SC_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        err_nxt      = sat_add(err_r, popcount6(mism));
        fv_nxt[idx]  = fv_r[idx] | (|mism);
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
        if (!ffv_r && (|mism)) begin
          ffi_nxt = idx;
          ffy_nxt = bus.y;
          ffv_nxt = 1'b1;
        end
`endif
        if (idx == 2'd3) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == '0);
        end else begin
          state_nxt = SETTLE;
          idx_nxt   = idx + 2'd1;
          a_nxt     = idx_nxt[1];
          b_nxt     = idx_nxt[0];
          scnt_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 2'd0;
      scnt   <= '0;
      a_r    <= 1'b0;
      b_r    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
      err_r  <= '0;
      fv_r   <= 4'b0000;
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
      ffi_r  <= 2'd0;
      ffy_r  <= 6'd0;
      ffv_r  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      scnt   <= scnt_nxt;
      a_r    <= a_nxt;
      b_r    <= b_nxt;
      busy_r <= busy_nxt;
      done_r <= done_nxt;
      pass_r <= pass_nxt;
      err_r  <= err_nxt;
      fv_r   <= fv_nxt;
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
      ffi_r  <= ffi_nxt;
      ffy_r  <= ffy_nxt;
      ffv_r  <= ffv_nxt;
`endif
    end
  end

  assign bus.a        = a_r;
  assign bus.b        = b_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pass     = pass_r;
  assign bus.err_cnt  = err_r;
  assign bus.fail_vec = fv_r;
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
  assign bus.first_fail_idx = ffi_r;
  assign bus.first_fail_y   = ffy_r;
  assign bus.first_fail_vld = ffv_r;
`endif

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench for gate_tester: a faultable gate-block model feeds y, a scoreboard holds run results.
`timescale 1ns/1ps
module tb_gate_tester;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_sig;
  logic [1:0] mode8;

  always #5 clk = ~clk;

  gate_tester_if #(.CNT_W(8)) bus8 ();
  gate_tester_if #(.CNT_W(2)) bus2 ();

  // mode 0: correct gates; 1: y5 stuck at 0; 2: y2 wired to a; 3: every output inverted
  function automatic logic [5:0] gate_y(input logic ga, input logic gb, input logic [1:0] mode);
    logic [5:0] y;
    y = {ga ^ gb, ~(ga | gb), ~(ga & gb), ~ga, ga | gb, ga & gb};
    case (mode)
      2'd1:    y[5] = 1'b0;
      2'd2:    y[2] = ga;
      2'd3:    y = ~y;
      default: ;
    endcase
    return y;
  endfunction

  assign bus8.start = start_sig;
  assign bus2.start = start_sig;
  assign bus8.y     = gate_y(bus8.a, bus8.b, mode8);
  assign bus2.y     = gate_y(bus2.a, bus2.b, 2'd3);

  gate_tester #(.SETTLE_CYCLES(2), .CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  gate_tester #(.SETTLE_CYCLES(2), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    int         err;
    logic [3:0] fv;
    logic       pass;
    logic [1:0] ffi;
    logic [5:0] ffy;
    logic       ffv;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string name, input logic [1:0] mode, input bit pulses);
    logic [23:0] ab_obs, ab_exp;
    int          edges;
    exp_t        e;
    mode8 = mode;
    @(negedge clk);
    start_sig = 1'b1;
    @(posedge clk);
    #1;
    start_sig = 1'b0;
    check({name, "_start_busy"}, 32'(bus8.busy), 32'd1);
    check({name, "_start_done"}, 32'(bus8.done), 32'd0);
    check({name, "_start_err"},  32'(bus8.err_cnt), 32'd0);
    check({name, "_start_fv"},   32'(bus8.fail_vec), 32'd0);
    edges  = 0;
    ab_obs = '0;
    ab_exp = '0;
    ab_obs[1:0] = {bus8.a, bus8.b};
    while (!bus8.done && edges < 100) begin
      start_sig = pulses && (edges == 2 || edges == 6);
      @(posedge clk);
      #1;
      edges++;
      if (edges < 12) begin
        ab_obs[2*edges +: 2] = {bus8.a, bus8.b};
        ab_exp[2*edges +: 2] = 2'(edges / 3);
      end
    end
    start_sig = 1'b0;
    check({name, "_done_edge"}, 32'(edges), 32'd12);
    check({name, "_ab_seq"}, 32'(ab_obs), 32'(ab_exp));
    check({name, "_ab_done"}, 32'({bus8.a, bus8.b}), 32'd3);
    check({name, "_busy_done"}, 32'(bus8.busy), 32'd0);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_err_cnt"},  32'(bus8.err_cnt), 32'(e.err));
      check({name, "_fail_vec"}, 32'(bus8.fail_vec), 32'(e.fv));
      check({name, "_pass"},     32'(bus8.pass), 32'(e.pass));
`ifdef GATE_TESTER_FAIL_CAPTURE_EN
      check({name, "_ff_vld"}, 32'(bus8.first_fail_vld), 32'(e.ffv));
      check({name, "_ff_idx"}, 32'(bus8.first_fail_idx), 32'(e.ffi));
      check({name, "_ff_y"},   32'(bus8.first_fail_y), 32'(e.ffy));
`endif
    end
  endtask

  initial begin
    rst       = 1'b1;
    start_sig = 1'b0;
    mode8     = 2'd0;
    #12;
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_pass", 32'(bus8.pass), 32'd0);
    check("rst_ab",   32'({bus8.a, bus8.b}), 32'd0);
    check("rst_err",  32'(bus8.err_cnt), 32'd0);
    check("rst_fv",   32'(bus8.fail_vec), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold_busy", 32'(bus8.busy), 32'd0);

    sb.push_back('{0, 4'b0000, 1'b1, 2'd0, 6'b000000, 1'b0});
    run("good", 2'd0, 1'b0);

    sb.push_back('{2, 4'b0110, 1'b0, 2'd1, 6'b001110, 1'b1});
    run("y5_stuck0", 2'd1, 1'b0);

    sb.push_back('{4, 4'b1111, 1'b0, 2'd0, 6'b011000, 1'b1});
    run("y2_eq_a_pulsed", 2'd2, 1'b1);

    // Abort a run while idx=2 is settling and confirm reset acts without a clock edge.
    mode8 = 2'd2;
    @(negedge clk);
    start_sig = 1'b1;
    @(posedge clk);
    #1;
    start_sig = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre_rst_ab",  32'({bus8.a, bus8.b}), 32'd2);
    check("pre_rst_err", 32'(bus8.err_cnt), 32'd2);
    rst = 1'b1;
    #1;
    check("async_rst_ab",   32'({bus8.a, bus8.b}), 32'd0);
    check("async_rst_busy", 32'(bus8.busy), 32'd0);
    check("async_rst_done", 32'(bus8.done), 32'd0);
    check("async_rst_err",  32'(bus8.err_cnt), 32'd0);
    check("async_rst_fv",   32'(bus8.fail_vec), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_busy", 32'(bus8.busy), 32'd0);
    check("post_rst_done", 32'(bus8.done), 32'd0);
    check("post_rst_ab",   32'({bus8.a, bus8.b}), 32'd0);

    sb.push_back('{24, 4'b1111, 1'b0, 2'd0, 6'b100011, 1'b1});
    run("all_inv", 2'd3, 1'b0);
    check("sat_done",    32'(bus2.done), 32'd1);
    check("sat_err_cnt", 32'(bus2.err_cnt), 32'd3);
    check("sat_fv",      32'(bus2.fail_vec), 32'd15);
    check("sat_pass",    32'(bus2.pass), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check("done_hold",     32'(bus8.done), 32'd1);
    check("done_hold_err", 32'(bus8.err_cnt), 32'd24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_tester.md
Name: gate_tester

Overview:
- Self-test sequencer wrapped around the two-input gate block (AND, OR, NOT-a, NAND, NOR, XOR outputs y0..y5).
- Drives the gate block's a/b inputs through all four input combinations and waits a programmable settle time.
- Samples y0..y5 and compares them against the golden truth table.
- Reports a pass/fail summary, a mismatch count and a per-vector fail map.
- Sits directly upstream (feeds a, b) and downstream (consumes y0..y5) of the gate block.

Parameters:
- SETTLE_CYCLES, 2, cycles a/b are held before sampling; legal range >= 1.
- CNT_W, 8, width of the mismatch counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- a  output  1  gate-block input a (registered).
- b  output  1  gate-block input b (registered).
- y  input  6  gate-block outputs {y5,y4,y3,y2,y1,y0}.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start.
- pass  output  1  valid while done: 1 when err_cnt==0.
- err_cnt  output  CNT_W  total mismatched output bits in the last run.
- fail_vec  output  4  bit i set when vector i had any mismatch.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- rst asserted at any time, including mid-run: immediately force
  - state=IDLE
  - a=0, b=0
  - busy=0, done=0, pass=0
  - err_cnt=0, fail_vec=0
  - idx=0, settle counter=0
- Vector index idx[1:0] runs 0..3, with a=idx[1] and b=idx[0].
- Golden outputs:
  - y0=a&b
  - y1=a|b
  - y2=~a
  - y3=~(a&b)
  - y4=~(a|b)
  - y5=a^b
- FSM states are IDLE, SETTLE, SAMPLE, DONE.
- IDLE / DONE + start=1:
  - idx=0, a=0, b=0
  - err_cnt=0, fail_vec=0
  - done=0, pass=0, busy=1
  - settle counter=0; go to SETTLE.
- IDLE / DONE + start=0: hold state and all outputs.
- SETTLE:
  - Increment the settle counter each cycle.
  - When counter==SETTLE_CYCLES-1, go to SAMPLE.
  - a/b are stable throughout SETTLE.
- SAMPLE (exactly 1 cycle):
  - mism = y XOR golden(idx).
  - err_cnt += popcount(mism), saturating at 2^CNT_W-1; no wrap.
  - fail_vec[idx] |= (mism!=0).
  - If idx==3: go to DONE with busy=0, done=1, and pass=(final err_cnt==0), using the post-update count.
  - Else: idx+1, update a/b from the new idx, settle counter=0, go to SETTLE.
- Timing:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises 4*(SETTLE_CYCLES+1) clock edges after the edge that accepted start.
  - That is 12 edges at the default SETTLE_CYCLES=2.
- start while busy=1 is ignored; no effect and no queuing.
- start held high continuously: the block restarts on the first cycle in DONE, so done is high for exactly 1 cycle between runs.
- In DONE, a/b hold the last vector (a=1, b=1).
- err_cnt, fail_vec and pass hold their values until the next accepted start or reset.
- y is sampled only in SAMPLE; y activity in other states is ignored.

Optional Feature:
- Macro: GATE_TESTER_FAIL_CAPTURE_EN.
- Defined:
  - Adds output first_fail_idx[1:0] and output first_fail_y[5:0], both reset to 0 and cleared on accepted start.
  - On the first SAMPLE of a run with a mismatch, they latch idx and the raw observed y.
  - Later mismatches in the same run do not overwrite them.
  - Adds output first_fail_vld, set at that capture and cleared on accepted start or reset.
- Undefined: these three ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Correct gate model, SETTLE_CYCLES=2, 1-cycle start pulse -> a/b sequence 00,01,10,11 each held 3 cycles; done=1 at edge 12 with pass=1, err_cnt=0, fail_vec=4'b0000.
- y5 stuck at 0 -> mismatches at ab=01 and ab=10 -> err_cnt=2, fail_vec=4'b0110, pass=0; with the macro, first_fail_idx=1 and first_fail_y=6'b001110.
- y2 wired to a instead of ~a -> every vector mismatches -> err_cnt=4, fail_vec=4'b1111, pass=0.
- start pulsed at edges 3 and 7 of a run -> ignored, done still at edge 12; start in DONE -> err_cnt, fail_vec and done clear on the next edge and a new run begins.
- rst asserted during SETTLE of idx=2 -> a=b=0, busy=0, done=0, err_cnt=0, fail_vec=0 without waiting for a clock edge; after release the block stays in IDLE until start.
- CNT_W=2, all six y bits inverted -> 24 raw mismatches -> err_cnt saturates at 3 (no wrap), fail_vec=4'b1111.
